// File: rtl/timer_bus_driver.sv
// rtl/timer_bus_driver.sv - Avalon-MM initiator sequencing interval-timer register accesses
// Optional feature macro: TIMER_BUS_DRIVER_IRQ_SERVICE_EN (hardware timeout servicing)
module timer_bus_driver #(
  parameter int EVT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_period,
  input  logic             cmd_continuous,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             tick,
  output logic [EVT_W-1:0] event_count,
  output logic [2:0]       av_address,
  output logic             av_chipselect,
  output logic             av_write_n,
  output logic [15:0]      av_writedata,
  input  logic [15:0]      av_readdata,
  input  logic             irq
);

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_STOP   = 2'd1;
  localparam logic [1:0] OP_SNAP   = 2'd2;
  localparam logic [1:0] OP_STATUS = 2'd3;

`ifdef TIMER_BUS_DRIVER_IRQ_SERVICE_EN
  localparam logic ITO_BIT = 1'b1;
`else
  localparam logic ITO_BIT = 1'b0;
  logic unused_irq;
  assign unused_irq = irq;
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
`ifdef TIMER_BUS_DRIVER_IRQ_SERVICE_EN
    ST_IRQ_CLR,
`endif
    ST_START_PL,
    ST_START_PH,
    ST_START_CTL,
    ST_STOP_CTL,
    ST_STOP_ST,
    ST_SNAP_WR,
    ST_SNAP_RL,
    ST_SNAP_RH,
    ST_SNAP_CAP,
    ST_STAT_RD,
    ST_STAT_CAP,
    ST_RSP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] period_hi_q;
  logic        cont_q;
  logic [15:0] snap_lo_q;
  logic        bus_cs_d;
  logic        bus_write_n_d;
  logic [2:0]  bus_addr_d;
  logic [15:0] bus_wdata_d;
  logic        accept;

`ifdef TIMER_BUS_DRIVER_IRQ_SERVICE_EN
  assign cmd_ready = (state_q == ST_IDLE) && !irq;
`else
  assign cmd_ready = (state_q == ST_IDLE);
`endif
  assign accept = cmd_valid && cmd_ready;

  // Next state: interrupt service beats a pending command, then walk the op's access list
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef TIMER_BUS_DRIVER_IRQ_SERVICE_EN
        if (irq) begin
          state_d = ST_IRQ_CLR;
        end else
`endif
        if (accept) begin
          case (cmd_op)
            OP_START: state_d = ST_START_PL;
            OP_STOP:  state_d = ST_STOP_CTL;
            OP_SNAP:  state_d = ST_SNAP_WR;
            default:  state_d = ST_STAT_RD;
          endcase
        end
      end
`ifdef TIMER_BUS_DRIVER_IRQ_SERVICE_EN
      ST_IRQ_CLR:   state_d = ST_IDLE;
`endif
      ST_START_PL:  state_d = ST_START_PH;
      ST_START_PH:  state_d = ST_START_CTL;
      ST_START_CTL: state_d = ST_RSP;
      ST_STOP_CTL:  state_d = ST_STOP_ST;
      ST_STOP_ST:   state_d = ST_RSP;
      ST_SNAP_WR:   state_d = ST_SNAP_RL;
      ST_SNAP_RL:   state_d = ST_SNAP_RH;
      ST_SNAP_RH:   state_d = ST_SNAP_CAP;
      ST_SNAP_CAP:  state_d = ST_RSP;
      ST_STAT_RD:   state_d = ST_STAT_CAP;
      ST_STAT_CAP:  state_d = ST_RSP;
      ST_RSP:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Bus access for the upcoming state; registered so the access lines up with that state
  always_comb begin
    bus_cs_d      = 1'b0;
    bus_write_n_d = 1'b1;
    bus_addr_d    = REG_STATUS;
    bus_wdata_d   = 16'h0000;
    case (state_d)
`ifdef TIMER_BUS_DRIVER_IRQ_SERVICE_EN
      ST_IRQ_CLR: begin
        bus_cs_d = 1'b1; bus_write_n_d = 1'b0; bus_addr_d = REG_STATUS;
      end
`endif
      ST_START_PL: begin
        // Only reachable from the accept edge, so the live command period is valid here
        bus_cs_d = 1'b1; bus_write_n_d = 1'b0; bus_addr_d = REG_PERIODL;
        bus_wdata_d = cmd_period[15:0];
      end
      ST_START_PH: begin
        bus_cs_d = 1'b1; bus_write_n_d = 1'b0; bus_addr_d = REG_PERIODH;
        bus_wdata_d = period_hi_q;
      end
      ST_START_CTL: begin
        bus_cs_d = 1'b1; bus_write_n_d = 1'b0; bus_addr_d = REG_CONTROL;
        bus_wdata_d = {12'h000, 1'b0, 1'b1, cont_q, ITO_BIT};
      end
      ST_STOP_CTL: begin
        bus_cs_d = 1'b1; bus_write_n_d = 1'b0; bus_addr_d = REG_CONTROL;
        bus_wdata_d = 16'h0008;
      end
      ST_STOP_ST, ST_SNAP_WR: begin
        bus_cs_d = 1'b1; bus_write_n_d = 1'b0;
        bus_addr_d = (state_d == ST_SNAP_WR) ? REG_SNAPL : REG_STATUS;
      end
      ST_SNAP_RL: begin
        bus_cs_d = 1'b1; bus_addr_d = REG_SNAPL;
      end
      ST_SNAP_RH: begin
        bus_cs_d = 1'b1; bus_addr_d = REG_SNAPH;
      end
      ST_STAT_RD: begin
        bus_cs_d = 1'b1; bus_addr_d = REG_STATUS;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Registered Avalon outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      av_address    <= 3'd0;
      av_writedata  <= 16'h0000;
    end else begin
      av_chipselect <= bus_cs_d;
      av_write_n    <= bus_write_n_d;
      av_address    <= bus_addr_d;
      av_writedata  <= bus_wdata_d;
    end
  end

  // Command capture at accept and snapshot low half one cycle after the R4 access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_hi_q <= 16'h0000;
      cont_q      <= 1'b0;
      snap_lo_q   <= 16'h0000;
    end else begin
      if (accept) begin
        period_hi_q <= cmd_period[31:16];
        cont_q      <= cmd_continuous;
      end
      if (state_q == ST_SNAP_RH) snap_lo_q <= av_readdata;
    end
  end

  // Completion pulse with data; data holds until the next completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
    end else begin
      rsp_valid <= (state_d == ST_RSP);
      if (state_d == ST_RSP) begin
        case (state_q)
          ST_SNAP_CAP: rsp_data <= {av_readdata, snap_lo_q};
          ST_STAT_CAP: rsp_data <= {30'h0, av_readdata[1:0]};
          default:     rsp_data <= 32'h0;
        endcase
      end
    end
  end

`ifdef TIMER_BUS_DRIVER_IRQ_SERVICE_EN
  // Timeout bookkeeping: one tick and one count the cycle after the status clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick        <= 1'b0;
      event_count <= '0;
    end else begin
      tick <= (state_q == ST_IRQ_CLR);
      if (state_q == ST_IRQ_CLR) event_count <= event_count + {{(EVT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign tick        = 1'b0;
  assign event_count = '0;
`endif

endmodule

// File: tb/tb_timer_bus_driver.sv
// tb/tb_timer_bus_driver.sv - directed self-checking bench for timer_bus_driver with a timer slave model
module tb_timer_bus_driver;

  localparam int EVT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [31:0]      cmd_period = 32'h0;
  logic             cmd_continuous = 1'b0;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic             tick;
  logic [EVT_W-1:0] event_count;
  logic [2:0]       av_address;
  logic             av_chipselect;
  logic             av_write_n;
  logic [15:0]      av_writedata;
  logic [15:0]      av_readdata = 16'h0;
  logic             irq;

  int checks = 0;
  int errors = 0;

  timer_bus_driver #(.EVT_W(EVT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tick(tick), .event_count(event_count),
    .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Timer slave model
  logic        to_flag = 1'b0;
  logic        run_flag = 1'b0;
  logic        ctl_ito = 1'b0;
  logic        fire_to = 1'b0;
  logic        irq_force = 1'b0;
  logic [31:0] snap_src = 32'h0;
  logic [31:0] snap_latch = 32'h0;

  assign irq = (to_flag & ctl_ito) | irq_force;

  always @(posedge clk) begin
    if (fire_to) to_flag <= 1'b1;
    if (av_chipselect && !av_write_n) begin
      case (av_address)
        3'd0: to_flag <= 1'b0;
        3'd1: begin
          ctl_ito <= av_writedata[0];
          if (av_writedata[2]) run_flag <= 1'b1;
          if (av_writedata[3]) run_flag <= 1'b0;
        end
        3'd4, 3'd5: snap_latch <= snap_src;
        default: ;
      endcase
    end
    if (av_chipselect && av_write_n) begin
      case (av_address)
        3'd0:    av_readdata <= {14'h0, run_flag, to_flag};
        3'd4:    av_readdata <= snap_latch[15:0];
        3'd5:    av_readdata <= snap_latch[31:16];
        default: av_readdata <= 16'h0;
      endcase
    end
  end

  // Bus access log and tick counter
  logic [31:0] bus_log[$];
  int tick_cnt = 0;

  always @(negedge clk) begin
    if (av_chipselect)
      bus_log.push_back(av_write_n ? {12'h0, av_address, 1'b0, 16'h0}
                                   : {12'h0, av_address, 1'b1, av_writedata});
    if (tick) tick_cnt++;
  end

  function automatic logic [31:0] bw(input logic [2:0] a, input logic [15:0] d);
    return {12'h0, a, 1'b1, d};
  endfunction

  function automatic logic [31:0] br(input logic [2:0] a);
    return {12'h0, a, 1'b0, 16'h0};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < bus_log.size()) return bus_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns at the falling edge where rsp_valid is seen
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] period, input logic cont,
                        output int lat, output logic [31:0] data);
    int n;
    bus_log.delete();
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_period = period;
    cmd_continuous = cont;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", {31'h0, cmd_ready}, 32'h1);
      cmd_valid = 1'b0;
      lat = -1;
      data = 32'h0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) lat = -1;
    data = rsp_data;
  endtask

  initial begin
    int lat;
    logic [31:0] d;
    int rsp_seen;

    repeat (2) @(negedge clk);
    check("rst_cs", {31'h0, av_chipselect}, 32'h0);
    check("rst_wn", {31'h0, av_write_n}, 32'h1);
    check("rst_addr", {29'h0, av_address}, 32'h0);
    check("rst_wdata", {16'h0, av_writedata}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_tick", {31'h0, tick}, 32'h0);
    check("rst_evt", {28'h0, event_count}, 32'h0);
    check("rst_ready", {31'h0, cmd_ready}, 32'h1);
    reset_n = 1'b1;
    step();

    do_cmd(2'd0, 32'h0001_869F, 1'b1, lat, d);
    check("start_lat", lat, 4);
    check("start_nacc", bus_log.size(), 3);
    check("start_pl", log_at(0), bw(3'd2, 16'h869F));
    check("start_ph", log_at(1), bw(3'd3, 16'h0001));
`ifdef TIMER_BUS_DRIVER_IRQ_SERVICE_EN
    check("start_ctl", log_at(2), bw(3'd1, 16'h0007));
`else
    check("start_ctl", log_at(2), bw(3'd1, 16'h0006));
`endif
    check("start_rsp", d, 32'h0);
    @(negedge clk);
    check("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
    check("cs_idle", {31'h0, av_chipselect}, 32'h0);

    snap_src = 32'h0001_2345;
    step();
    do_cmd(2'd2, 32'h0, 1'b0, lat, d);
    check("snap_lat", lat, 5);
    check("snap_nacc", bus_log.size(), 3);
    check("snap_w4", log_at(0), bw(3'd4, 16'h0));
    check("snap_r4", log_at(1), br(3'd4));
    check("snap_r5", log_at(2), br(3'd5));
    check("snap_rsp", d, 32'h0001_2345);

    step();
    do_cmd(2'd3, 32'h0, 1'b0, lat, d);
    check("stat_lat", lat, 3);
    check("stat_r0", log_at(0), br(3'd0));
    check("stat_run", d, 32'h2);

    step();
    do_cmd(2'd1, 32'h0, 1'b0, lat, d);
    check("stop_lat", lat, 3);
    check("stop_ctl", log_at(0), bw(3'd1, 16'h0008));
    check("stop_st", log_at(1), bw(3'd0, 16'h0));
    check("stop_rsp", d, 32'h0);

    step();
    do_cmd(2'd3, 32'h0, 1'b0, lat, d);
    check("stat_stopped", d, 32'h0);

    step();
    do_cmd(2'd0, 32'h0000_0010, 1'b0, lat, d);
    check("start2_lat", lat, 4);
    check("start2_pl", log_at(0), bw(3'd2, 16'h0010));
`ifdef TIMER_BUS_DRIVER_IRQ_SERVICE_EN
    check("start2_ctl", log_at(2), bw(3'd1, 16'h0005));

    // irq and a STATUS command together: clear first, then the command
    step();
    tick_cnt = 0;
    fire_to = 1'b1;
    step();
    fire_to = 1'b0;
    do_cmd(2'd3, 32'h0, 1'b0, lat, d);
    check("irq_w0", log_at(0), bw(3'd0, 16'h0));
    check("irq_then_r0", log_at(1), br(3'd0));
    check("irq_tick", tick_cnt, 1);
    check("irq_evt", {28'h0, event_count}, 32'h1);
    check("irq_stat", d, 32'h2);

    // Fill the counter to all-ones, then wrap
    for (int i = 0; i < 14; i++) begin
      step();
      fire_to = 1'b1;
      step();
      fire_to = 1'b0;
      repeat (6) @(negedge clk);
    end
    check("evt_full", {28'h0, event_count}, 32'hF);
    check("evt_ticks", tick_cnt, 15);
    step();
    fire_to = 1'b1;
    step();
    fire_to = 1'b0;
    repeat (6) @(negedge clk);
    check("evt_wrap", {28'h0, event_count}, 32'h0);
    check("evt_wrap_tick", tick_cnt, 16);
`else
    check("start2_ctl", log_at(2), bw(3'd1, 16'h0004));

    // irq is ignored entirely
    irq_force = 1'b1;
    tick_cnt = 0;
    step();
    bus_log.delete();
    repeat (8) @(negedge clk);
    check("noirq_bus", bus_log.size(), 0);
    check("noirq_tick", tick_cnt, 0);
    check("noirq_evt", {28'h0, event_count}, 32'h0);
    step();
    do_cmd(2'd3, 32'h0, 1'b0, lat, d);
    check("noirq_stat_lat", lat, 3);
    check("noirq_stat", d, 32'h2);
    irq_force = 1'b0;
`endif

    // Reset in the middle of SNAP's R4 cycle
    step();
    bus_log.delete();
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    @(negedge clk);
    check("rst_snap_ready", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    step();
    check("rst_snap_r4", {28'h0, av_chipselect, av_write_n, av_address}, {28'h0, 1'b1, 1'b1, 3'd4});
    reset_n = 1'b0;
    #1;
    check("rst_async_cs", {31'h0, av_chipselect}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check("rst_no_rsp", rsp_seen, 0);
    check("rst_ready_after", {31'h0, cmd_ready}, 32'h1);
    check("rst_evt_after", {28'h0, event_count}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
